// File: rtl/kyber_pkg.sv
// Shared Kyber constants, widths and the NTT controller state type.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int NTT_LAYERS = 7;

  localparam int ADDR_W  = 8;
  localparam int TW_W    = 7;
  localparam int J_W     = 7;
  localparam int LAYER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ntt_state_e;

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register; every stage (including any valid bit in the word) clears on reset.
module ntt_delay_line #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst) q_reg <= '0;
          else      q_reg <= din;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!rst) q_reg <= '0;
          else      q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/ntt_ctrl.sv
// 256-point NTT/INTT sequencer: walks 7 layers of 128 butterflies, issues RAM/ROM
// addresses and a write-back stream delayed by the read + butterfly latency.
module ntt_ctrl
  import kyber_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [TW_W-1:0]   tw_addr,
  output logic              ct,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);

  localparam int PIPE_LAT = RD_LAT + BF_LAT;
  localparam int CNT_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DL_W     = 1 + 2 * ADDR_W;

  localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(PIPE_LAT - 1);
  localparam logic [J_W-1:0]     J_LAST     = J_W'(KYBER_N / 2 - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NTT_LAYERS - 1);

  ntt_state_e         state_reg, state_next;
  logic [LAYER_W-1:0] layer_reg, layer_next;
  logic [J_W-1:0]     j_reg, j_next;
  logic [CNT_W-1:0]   drain_reg, drain_next;
  logic               gs_reg, gs_next;
  logic               ct_reg, ct_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      layer_reg <= '0;
      j_reg     <= '0;
      drain_reg <= '0;
      gs_reg    <= 1'b0;
      ct_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      layer_reg <= layer_next;
      j_reg     <= j_next;
      drain_reg <= drain_next;
      gs_reg    <= gs_next;
      ct_reg    <= ct_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    j_next     = j_reg;
    drain_next = drain_reg;
    gs_next    = gs_reg;
    ct_next    = ct_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          layer_next = '0;
          j_next     = '0;
          gs_next    = mode;
          ct_next    = ~mode;
        end
      end
      ST_RUN: begin
        j_next = j_reg + 1'b1;
        if (j_reg == J_LAST) begin
          state_next = ST_DRAIN;
          j_next     = '0;
          drain_next = '0;
        end
      end
      ST_DRAIN: begin
        // Wait out the pipeline so the next layer never reads a word still in flight.
        if (drain_reg == DRAIN_LAST) begin
          drain_next = '0;
          if (layer_reg == LAYER_LAST) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_RUN;
            layer_next = layer_reg + 1'b1;
          end
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done = (state_reg == ST_DONE);
  assign ct   = ct_reg;

  // len-1 and log2(len) are derived by shifting so every term stays within 7/8 bits.
  logic [3:0]        sh;
  logic [J_W-1:0]    lenm1;
  logic [J_W-1:0]    grp;
  logic [J_W-1:0]    off;
  logic [ADDR_W-1:0] base;

  always_comb begin
    if (gs_reg) begin
      lenm1 = 7'h7F >> (3'd6 - layer_reg);
      sh    = {1'b0, layer_reg} + 4'd1;
    end else begin
      lenm1 = 7'h7F >> layer_reg;
      sh    = 4'd7 - {1'b0, layer_reg};
    end
    grp  = j_reg >> sh;
    off  = j_reg & lenm1;
    base = ({1'b0, grp} << (sh + 4'd1)) + {1'b0, off};

    rd_en     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_addr   = '0;
    if (state_reg == ST_RUN) begin
      rd_en     = 1'b1;
      rd_addr_a = base;
      rd_addr_b = base + {1'b0, lenm1} + 8'd1;
      if (gs_reg) tw_addr = (7'h7F >> layer_reg) - grp;
      else        tw_addr = (7'd1 << layer_reg) + grp;
    end
  end

  logic [DL_W-1:0] dl_in, dl_out;

  assign dl_in = {rd_en, rd_addr_a, rd_addr_b};

  ntt_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (DL_W)
  ) u_wb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = dl_out;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: default instance plus a BF_LAT=2 instance for drain timing.
module tb_ntt_ctrl;
  import kyber_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, mode, start2, mode2;
  logic       busy, done, rd_en, ct, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_addr;
  logic       busy2, done2, rd_en2, ct2, wr_en2;
  logic [7:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
  logic [6:0] tw_addr2;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [16:0] hist [0:1023];

  always #5 clk = ~clk;

  ntt_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .ct(ct), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  ntt_ctrl #(.BF_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2),
    .busy(busy2), .done(done2), .rd_en(rd_en2),
    .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
    .ct(ct2), .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    int done_seen;
    rst = 1'b0; start = 1'b0; mode = 1'b0; start2 = 1'b0; mode2 = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    vec_cnt++;
    if ({busy, done, rd_en, wr_en, ct} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, rd_en, wr_en, ct});
    vec_cnt++;
    if ({rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 39'd0)
      $display("FAIL reset_addr: got %h want 0", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    vec_cnt++;
    if (dut.state_reg !== ST_IDLE)
      $display("FAIL reset_state: got %0d want %0d", dut.state_reg, ST_IDLE);
    vec_cnt++;
    if ({busy2, done2, rd_en2, wr_en2, ct2, rd_addr_a2, wr_addr_b2} !== 21'd0)
      $display("FAIL reset_dut2: got %h want 0", {busy2, done2, rd_en2, wr_en2, ct2, rd_addr_a2, wr_addr_b2});
    done_seen = 0;
    repeat (5) begin
      tick();
      if (done || busy) done_seen++;
    end
    vec_cnt++;
    if (done_seen !== 0) begin
      err_cnt++;
      $display("FAIL idle_no_done: got %0d active cycles want 0", done_seen);
    end
    $display("test_reset: checked reset outputs and idle");
  endtask

  // Forward run with a start/mode pulse injected mid-run that must be ignored.
  task automatic test_ct_run;
    int rdn, wrn, busy_n, done_c, done_n, ct_bad;
    logic [22:0] exp;
    bit chk;
    rdn = 0; wrn = 0; busy_n = 0; done_c = -1; done_n = 0; ct_bad = 0;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 940; c++) begin
      hist[c] = {rd_en, rd_addr_a, rd_addr_b};
      if (busy) busy_n++;
      if (wr_en) wrn++;
      vec_cnt++;
      if ({wr_en, wr_addr_a, wr_addr_b} !== ((c >= 5) ? hist[c-5] : 17'd0)) begin
        err_cnt++;
        $display("FAIL ct_wr_delay c=%0d: got %h want %h", c, {wr_en, wr_addr_a, wr_addr_b},
                 (c >= 5) ? hist[c-5] : 17'd0);
      end
      if (busy && ct !== 1'b1) ct_bad++;
      if (rd_en) begin
        chk = 1'b1;
        case (rdn)
          0:       exp = {8'd0,   8'd128, 7'd1};
          127:     exp = {8'd127, 8'd255, 7'd1};
          128:     exp = {8'd0,   8'd64,  7'd2};
          192:     exp = {8'd128, 8'd192, 7'd3};
          895:     exp = {8'd253, 8'd255, 7'd127};
          default: begin chk = 1'b0; exp = '0; end
        endcase
        if (chk) begin
          vec_cnt++;
          if ({rd_addr_a, rd_addr_b, tw_addr} !== exp) begin
            err_cnt++;
            $display("FAIL ct_addr idx=%0d: got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                     rdn, rd_addr_a, rd_addr_b, tw_addr, exp[22:15], exp[14:7], exp[6:0]);
          end
        end
        rdn++;
      end
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (c == 300) begin start = 1'b1; mode = 1'b1; end
      else if (c == 301) begin start = 1'b0; mode = 1'b0; end
      tick();
    end
    vec_cnt++;
    if (busy_n !== 931) begin err_cnt++; $display("FAIL ct_busy_len: got %0d want 931", busy_n); end
    vec_cnt++;
    if (rdn !== 896) begin err_cnt++; $display("FAIL ct_rd_count: got %0d want 896", rdn); end
    vec_cnt++;
    if (wrn !== 896) begin err_cnt++; $display("FAIL ct_wr_count: got %0d want 896", wrn); end
    vec_cnt++;
    if (done_c !== 931 || done_n !== 1) begin
      err_cnt++;
      $display("FAIL ct_done: got cycle %0d count %0d want cycle 931 count 1", done_c, done_n);
    end
    vec_cnt++;
    if (ct_bad !== 0) begin err_cnt++; $display("FAIL ct_hold: got %0d bad cycles want 0", ct_bad); end
    $display("test_ct_run: rd=%0d wr=%0d busy=%0d done@%0d", rdn, wrn, busy_n, done_c);
  endtask

  task automatic test_gs_run;
    int rdn, busy_n, done_c, ct_bad;
    logic [22:0] exp;
    bit chk;
    rdn = 0; busy_n = 0; done_c = -1; ct_bad = 0;
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    for (int c = 0; c < 940; c++) begin
      if (busy) busy_n++;
      if (busy && ct !== 1'b0) ct_bad++;
      if (done && done_c < 0) done_c = c;
      if (rd_en) begin
        chk = 1'b1;
        case (rdn)
          0:       exp = {8'd0,   8'd2,   7'd127};
          261:     exp = {8'd5,   8'd13,  7'd31};
          404:     exp = {8'd36,  8'd52,  7'd14};
          768:     exp = {8'd0,   8'd128, 7'd1};
          895:     exp = {8'd127, 8'd255, 7'd1};
          default: begin chk = 1'b0; exp = '0; end
        endcase
        if (chk) begin
          vec_cnt++;
          if ({rd_addr_a, rd_addr_b, tw_addr} !== exp) begin
            err_cnt++;
            $display("FAIL gs_addr idx=%0d: got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                     rdn, rd_addr_a, rd_addr_b, tw_addr, exp[22:15], exp[14:7], exp[6:0]);
          end
        end
        rdn++;
      end
      tick();
    end
    vec_cnt++;
    if (ct_bad !== 0) begin err_cnt++; $display("FAIL gs_ct_zero: got %0d bad cycles want 0", ct_bad); end
    vec_cnt++;
    if (busy_n !== 931) begin err_cnt++; $display("FAIL gs_busy_len: got %0d want 931", busy_n); end
    vec_cnt++;
    if (done_c !== 931) begin err_cnt++; $display("FAIL gs_done: got %0d want 931", done_c); end
    $display("test_gs_run: rd=%0d busy=%0d done@%0d", rdn, busy_n, done_c);
  endtask

  task automatic test_abort;
    int rdn, stray, c, done_c;
    bit hit;
    rdn = 0; hit = 1'b0;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (c = 0; c < 600 && !hit; c++) begin
      if (rd_en) begin
        if (rdn == 128) begin
          vec_cnt++;
          if ({rd_addr_a, rd_addr_b, tw_addr} !== {8'd0, 8'd64, 7'd2}) begin
            err_cnt++;
            $display("FAIL abort_ignore_start: got a=%0d b=%0d tw=%0d want a=0 b=64 tw=2",
                     rd_addr_a, rd_addr_b, tw_addr);
          end
        end
        rdn++;
      end
      if (rdn == 394) hit = 1'b1;
      else begin
        if (c == 100) begin start = 1'b1; mode = 1'b1; end
        else if (c == 101) begin start = 1'b0; mode = 1'b0; end
        tick();
      end
    end
    vec_cnt++;
    if (!hit) begin err_cnt++; $display("FAIL abort_reach_layer3: got %0d reads want 394", rdn); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vec_cnt++;
    if ({busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 43'd0) begin
      err_cnt++;
      $display("FAIL abort_outputs: got %h want 0",
               {busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    stray = 0;
    repeat (20) begin
      tick();
      if (wr_en || busy) stray++;
    end
    vec_cnt++;
    if (stray !== 0) begin err_cnt++; $display("FAIL abort_stray_wr: got %0d want 0", stray); end
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    vec_cnt++;
    if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== {1'b1, 8'd0, 8'd128, 7'd1}) begin
      err_cnt++;
      $display("FAIL abort_restart: got en=%b a=%0d b=%0d tw=%0d want en=1 a=0 b=128 tw=1",
               rd_en, rd_addr_a, rd_addr_b, tw_addr);
    end
    done_c = -1;
    for (int k = 0; k < 1000 && done_c < 0; k++) begin
      if (done) done_c = k;
      else tick();
    end
    vec_cnt++;
    if (done_c !== 931) begin err_cnt++; $display("FAIL abort_rerun_done: got %0d want 931", done_c); end
    tick();
    $display("test_abort: reset at read %0d, rerun done@%0d", rdn, done_c);
  endtask

  task automatic test_bf2_drain;
    int rdn, busy_n, t_last_rd, t_first_rd, t_last_wr, done_c;
    ntt_state_e st_after;
    rdn = 0; busy_n = 0; t_last_rd = -1; t_first_rd = -1; t_last_wr = -1; done_c = -1;
    st_after = ST_IDLE;
    start2 = 1'b1; mode2 = 1'b0;
    tick();
    start2 = 1'b0;
    for (int c = 0; c < 930; c++) begin
      if (busy2) busy_n++;
      if (done2 && done_c < 0) done_c = c;
      if (t_last_rd >= 0 && c == t_last_rd + 1) st_after = dut2.state_reg;
      if (wr_en2 && wr_addr_a2 == 8'd127 && wr_addr_b2 == 8'd255 && t_last_wr < 0) t_last_wr = c;
      if (rd_en2) begin
        if (rdn == 127) t_last_rd = c;
        if (rdn == 128) t_first_rd = c;
        rdn++;
      end
      tick();
    end
    vec_cnt++;
    if (t_first_rd - t_last_rd - 1 !== 3) begin
      err_cnt++;
      $display("FAIL bf2_drain_len: got %0d want 3", t_first_rd - t_last_rd - 1);
    end
    vec_cnt++;
    if (t_first_rd - t_last_wr !== 1) begin
      err_cnt++;
      $display("FAIL bf2_wr_to_rd: got %0d want 1", t_first_rd - t_last_wr);
    end
    vec_cnt++;
    if (st_after !== ST_DRAIN) begin
      err_cnt++;
      $display("FAIL bf2_state: got %0d want %0d", st_after, ST_DRAIN);
    end
    vec_cnt++;
    if (busy_n !== 917 || done_c !== 917) begin
      err_cnt++;
      $display("FAIL bf2_busy: got busy %0d done@%0d want 917/917", busy_n, done_c);
    end
    $display("test_bf2_drain: last_rd@%0d last_wr@%0d first_rd@%0d", t_last_rd, t_last_wr, t_first_rd);
  endtask

  initial begin
    test_reset();
    test_ct_run();
    test_gs_run();
    test_abort();
    test_bf2_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameters: RD_LAT, default 1, coefficient-RAM read latency in cycles; BF_LAT, default 4, butterfly input-to-E/O latency in cycles; PIPE_LAT = RD_LAT+BF_LAT (derived, not overridable).
REQ-002 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports: start  input  1  one-cycle request to run a full 256-point transform.
REQ-005 SHALL have ports: mode  input  1  0 = forward NTT (CT), 1 = inverse NTT (GS); sampled with start.
REQ-006 SHALL have ports: busy  output  1  transform in progress.
REQ-007 SHALL have ports: done  output  1  one-cycle pulse at completion.
REQ-008 SHALL have ports: rd_en  output  1  coefficient-RAM read strobe.
REQ-009 SHALL have ports: rd_addr_a, rd_addr_b  output  8 each  read addresses for butterfly A and B.
REQ-010 SHALL have ports: tw_addr  output  7  zeta-ROM index, valid with rd_en.
REQ-011 SHALL have ports: ct  output  1  butterfly CT select, = ~latched mode, held constant while busy.
REQ-012 SHALL have ports: wr_en  output  1  write-back strobe for E/O.
REQ-013 SHALL have ports: wr_addr_a, wr_addr_b  output  8 each  write-back addresses for E and O.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-015 SHALL transition IDLE->RUN on start=1, latching mode, and setting layer=0 and j=0; IDLE SHALL NOT leave on start=0.
REQ-016 SHALL, in RUN, assert rd_en every cycle for j = 0..127 (128 butterflies per layer), then transition to DRAIN.
REQ-017 SHALL remain in DRAIN for exactly PIPE_LAT cycles, then go to RUN with layer+1 if layer<6, else to DONE.
REQ-018 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-019 SHALL drive busy=1 in RUN and DRAIN only; with defaults, busy lasts 7*(128+5) = 931 cycles.
REQ-020 SHALL, for CT (mode=0): len = 128>>layer, grp = j>>log2(len), off = j&(len-1), rd_addr_a = 2*len*grp+off, rd_addr_b = rd_addr_a+len, tw_addr = (1<<layer)+grp.
REQ-021 SHALL, for GS (mode=1): len = 2<<layer, same grp/off/address rule, tw_addr = (128>>layer)-1-grp; ROM negation/ordering is outside this block.
REQ-022 SHALL delay rd_en, rd_addr_a and rd_addr_b by exactly PIPE_LAT cycles to produce wr_en, wr_addr_a and wr_addr_b.
REQ-023 SHALL, because of REQ-017, issue the last write of a layer in the cycle before the first read of the next layer; no read-before-write hazard is permitted.
REQ-024 SHALL ignore start while busy or in DONE; mode changes while busy SHALL have no effect.
REQ-025 SHALL keep all address computation in 8-bit unsigned arithmetic, with no wrap beyond 255 for any legal layer/j.
REQ-026 SHALL, outside RUN, drive rd_en=0 and hold rd_addr_a, rd_addr_b and tw_addr at 0.

Reset
REQ-027 SHALL, when rst=0 at a clock edge: set state=IDLE, layer=0, j=0, and drain counter 0, and clear every delay-line stage including its valid bits.
REQ-028 SHALL drive reset values of 0 on busy, done, rd_en, wr_en, all addresses, tw_addr and ct.
REQ-029 SHALL, on reset mid-transform, abort immediately with no further wr_en pulses; the next start SHALL begin from layer 0.

Structure
REQ-030 SHALL place in shared package kyber_pkg: KYBER_Q=3329, KYBER_N=256, NTT_LAYERS=7, the FSM state type, and the address/twiddle widths.
REQ-031 SHALL implement the PIPE_LAT write-back delay in one sub-module, ntt_delay_line, parameterised by depth and width.

Verification
REQ-032 SHALL verify: reset held 10 cycles, then released -> all outputs 0, state IDLE, no done.
REQ-033 SHALL verify: start with mode=0 -> first rd_en cycle gives a=0, b=128, tw=1; j=127 of layer 0 gives a=127, b=255, tw=1; layer 6 j=127 gives a=253, b=255, tw=127.
REQ-034 SHALL verify: start with mode=1 -> layer 0 j=0 gives a=0, b=2, tw=127; layer 6 j=0 gives a=0, b=128, tw=1; ct=0 throughout.
REQ-035 SHALL verify: full CT run with defaults -> busy high 931 cycles, 896 rd_en and 896 wr_en pulses, and each wr address equal to the rd address 5 cycles earlier.
REQ-036 SHALL verify: start pulsed mid-run, then rst=0 for 1 cycle at layer 3 -> start ignored, all outputs 0 next cycle, no stray wr_en, and a fresh start restarts at a=0, b=128.
REQ-037 SHALL verify: BF_LAT=2 override -> DRAIN lasts 3 cycles and the next layer's first read follows the previous layer's last write by exactly one cycle.
